// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with instruction and memory handshakes.
// Optional CTRL_PERF_EN adds retired_count/stall_count performance counters.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 16
`ifdef CTRL_PERF_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_code,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        Branch,
    output logic        Jump,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic [1:0]  ALUOp,
    output logic [2:0]  state,
    output logic        busy,
    output logic        illegal
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] stall_count
`endif
);

    localparam int unsigned TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       opcode_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_hit;
    logic             is_r, is_i, is_load, is_store, is_beq, is_jal, is_legal;
    logic             unused_instr;

    assign unused_instr = ^instruction_code[31:7];

    assign is_r     = (opcode_q == OP_R);
    assign is_i     = (opcode_q == OP_I);
    assign is_load  = (opcode_q == OP_LOAD);
    assign is_store = (opcode_q == OP_STORE);
    assign is_beq   = (opcode_q == OP_BEQ);
    assign is_jal   = (opcode_q == OP_JAL);
    assign is_legal = is_r | is_i | is_load | is_store | is_beq | is_jal;

    // Timeout fires on the last permitted waiting MEM cycle; mem_ready in that cycle still wins.
    assign tmo_hit = (MEM_TIMEOUT != 0) && (tmo_cnt_q == TMO_W'(MEM_TIMEOUT - 1));

    assign state = state_q;

    // State, latched opcode and MEM wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            opcode_q  <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && instr_valid) begin
                opcode_q <= instruction_code[6:0];
            end
            if (state_q == S_MEM && !mem_ready) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end else begin
                tmo_cnt_q <= '0;
            end
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        Branch      = 1'b0;
        Jump        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrc      = 1'b0;
        RegWrite    = 1'b0;
        ALUOp       = 2'b00;
        busy        = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                busy    = 1'b1;
                state_d = is_legal ? S_EXECUTE : S_TRAP;
            end
            S_EXECUTE: begin
                busy = 1'b1;
                if (is_r) begin
                    ALUOp   = 2'b10;
                    state_d = S_WB;
                end else if (is_i) begin
                    ALUOp   = 2'b10;
                    ALUSrc  = 1'b1;
                    state_d = S_WB;
                end else if (is_load || is_store) begin
                    ALUSrc  = 1'b1;
                    state_d = S_MEM;
                end else if (is_beq) begin
                    Branch  = 1'b1;
                    ALUOp   = 2'b01;
                    PCWrite = zero;
                    state_d = S_FETCH;
                end else if (is_jal) begin
                    Jump    = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_WB;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEM: begin
                busy     = 1'b1;
                ALUSrc   = 1'b1;
                MemRead  = is_load;
                MemWrite = is_store;
                if (mem_ready) begin
                    state_d = is_load ? S_WB : S_FETCH;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                busy     = 1'b1;
                RegWrite = 1'b1;
                MemtoReg = is_load;
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

`ifdef CTRL_PERF_EN
    logic retire_c, stall_c;

    assign retire_c = (state_q == S_WB)
                    | (state_q == S_EXECUTE && is_beq)
                    | (state_q == S_MEM && is_store && mem_ready);
    assign stall_c  = (state_q == S_FETCH && !instr_valid)
                    | (state_q == S_MEM && !mem_ready);

    // Free-running performance counters, wrapping naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_count <= '0;
            stall_count   <= '0;
        end else begin
            if (retire_c) retired_count <= retired_count + CNT_W'(1);
            if (stall_c)  stall_count   <= stall_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed table, corner-case sequences and random
// instruction streams checked cycle-by-cycle against a phase-schedule reference model.
module tb_multicycle_control;

    localparam int unsigned MEM_TIMEOUT = 16;

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_BEQ   = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;

    localparam int PH_F = 0;
    localparam int PH_D = 1;
    localparam int PH_E = 2;
    localparam int PH_M = 3;
    localparam int PH_W = 4;
    localparam int PH_T = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_code;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_ready;
    logic        zero;
    logic        IRWrite, PCWrite, Branch, Jump, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite;
    logic [1:0]  ALUOp;
    logic [2:0]  state;
    logic        busy;
    logic        illegal;
`ifdef CTRL_PERF_EN
    logic [31:0] retired_count;
    logic [31:0] stall_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int busy_seen;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .instruction_code (instruction_code),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .mem_ready        (mem_ready),
        .zero             (zero),
        .IRWrite          (IRWrite),
        .PCWrite          (PCWrite),
        .Branch           (Branch),
        .Jump             (Jump),
        .MemRead          (MemRead),
        .MemWrite         (MemWrite),
        .MemtoReg         (MemtoReg),
        .ALUSrc           (ALUSrc),
        .RegWrite         (RegWrite),
        .ALUOp            (ALUOp),
        .state            (state),
        .busy             (busy),
        .illegal          (illegal)
`ifdef CTRL_PERF_EN
        ,
        .retired_count    (retired_count),
        .stall_count      (stall_count)
`endif
    );

    typedef struct {
        logic [31:0] ins;
        logic        z;
        int          wt;
        int          exp_len;
        logic        exp_trap;
        string       name;
    } vec_t;

    function automatic logic is_legal_op(input logic [6:0] o);
        return (o == OP_R) || (o == OP_I) || (o == OP_LOAD) || (o == OP_STORE) ||
               (o == OP_BEQ) || (o == OP_JAL);
    endfunction

    // Expected control set for a phase, straight from the per-state control table
    function automatic logic [16:0] ref_out(input int ph, input logic [6:0] opc,
                                            input logic z, input logic iv);
        logic ir, irw, pcw, br, jp, mrd, mwr, m2r, asrc, rw, bsy, ill;
        logic [1:0] aop;
        {ir, irw, pcw, br, jp, mrd, mwr, m2r, asrc, rw, bsy, ill} = '0;
        aop = 2'b00;
        case (ph)
            PH_F: begin ir = 1'b1; irw = iv; pcw = iv; end
            PH_D: bsy = 1'b1;
            PH_E: begin
                bsy = 1'b1;
                if (opc == OP_R)                           aop = 2'b10;
                if (opc == OP_I)                 begin aop = 2'b10; asrc = 1'b1; end
                if (opc == OP_LOAD || opc == OP_STORE)     asrc = 1'b1;
                if (opc == OP_BEQ)               begin br = 1'b1; aop = 2'b01; pcw = z; end
                if (opc == OP_JAL)               begin jp = 1'b1; pcw = 1'b1; end
            end
            PH_M: begin
                bsy = 1'b1; asrc = 1'b1;
                mrd = (opc == OP_LOAD);
                mwr = (opc == OP_STORE);
            end
            PH_W: begin bsy = 1'b1; rw = 1'b1; m2r = (opc == OP_LOAD); end
            default: ill = 1'b1;
        endcase
        return {ir, irw, pcw, br, jp, mrd, mwr, m2r, asrc, rw, aop, 3'(ph), bsy, ill};
    endfunction

    function automatic logic [16:0] obs();
        return {instr_ready, IRWrite, PCWrite, Branch, Jump, MemRead, MemWrite, MemtoReg,
                ALUSrc, RegWrite, ALUOp, state, busy, illegal};
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, return at next posedge+1
    task automatic cyc(input int ph, input logic [6:0] opc, input logic iv, input logic mr,
                       input logic z, input logic [31:0] word, input string tag);
        instruction_code = word;
        instr_valid      = iv;
        mem_ready        = mr;
        zero             = z;
        @(negedge clk);
        cmp(tag, 32'(obs()), 32'(ref_out(ph, opc, z, iv)));
        if (busy) busy_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        zero        = 1'b0;
        @(negedge clk);
        cmp("reset_state", 32'(obs()), 32'(17'h10000));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Runs one instruction against a phase schedule built from the latency rules
    task automatic run_instr(input logic [31:0] ins, input logic z, input int wt, input int idle,
                             input int trap_hold, input string tag,
                             output int len, output logic trapped);
        logic [6:0] opc;
        int q[$];
        int ph, mem_k, n_mem;
        opc     = ins[6:0];
        trapped = 1'b0;
        q.push_back(PH_D);
        if (!is_legal_op(opc)) begin
            trapped = 1'b1;
        end else begin
            q.push_back(PH_E);
            if (opc == OP_LOAD || opc == OP_STORE) begin
                trapped = (MEM_TIMEOUT > 0) && (wt >= int'(MEM_TIMEOUT));
                n_mem   = trapped ? int'(MEM_TIMEOUT) : wt + 1;
                for (int k = 0; k < n_mem; k++) q.push_back(PH_M);
            end
            if (!trapped && opc != OP_BEQ && opc != OP_STORE) q.push_back(PH_W);
        end
        if (trapped) for (int k = 0; k < trap_hold; k++) q.push_back(PH_T);

        for (int k = 0; k < idle; k++)
            cyc(PH_F, opc, 1'b0, 1'($urandom), 1'($urandom), 32'($urandom), {tag, "_idle"});
        busy_seen = 0;
        cyc(PH_F, opc, 1'b1, 1'($urandom), 1'($urandom), ins, {tag, "_fetch"});
        mem_k = 0;
        while (q.size() > 0) begin
            ph = q.pop_front();
            if (ph == PH_M) begin
                cyc(ph, opc, 1'($urandom), (mem_k >= wt), 1'($urandom), 32'($urandom),
                    {tag, "_mem"});
                mem_k++;
            end else begin
                cyc(ph, opc, 1'($urandom), 1'($urandom), (ph == PH_E) ? z : 1'($urandom),
                    32'($urandom), {tag, "_ph"});
            end
        end
        len = busy_seen + 1;
    endtask

    vec_t tbl[8];
    int   len;
    logic trapped;

    initial begin
        instruction_code = '0;
        tbl[0] = '{32'h003100B3, 1'b0, 0,  4,  1'b0, "add"};
        tbl[1] = '{32'h00012083, 1'b0, 3,  8,  1'b0, "lw_wait3"};
        tbl[2] = '{32'h00112023, 1'b0, 0,  4,  1'b0, "sw_nowait"};
        tbl[3] = '{32'h00208463, 1'b1, 0,  3,  1'b0, "beq_taken"};
        tbl[4] = '{32'h00208463, 1'b0, 0,  3,  1'b0, "beq_not"};
        tbl[5] = '{32'h008000EF, 1'b0, 0,  4,  1'b0, "jal"};
        tbl[6] = '{32'h00012083, 1'b0, 15, 20, 1'b0, "lw_ready_at_limit"};
        tbl[7] = '{32'h0000007F, 1'b0, 0,  2,  1'b1, "illegal_op"};

        do_reset();

        foreach (tbl[i]) begin
            run_instr(tbl[i].ins, tbl[i].z, tbl[i].wt, i % 3, 2, tbl[i].name, len, trapped);
            cmp({tbl[i].name, "_len"}, 32'(len), 32'(tbl[i].exp_len));
            cmp({tbl[i].name, "_illegal"}, 32'(illegal), 32'(tbl[i].exp_trap));
            if (tbl[i].exp_trap) do_reset();
        end

        // Memory never answers: trap after MEM_TIMEOUT MEM cycles, then stays trapped
        run_instr(32'h00012083, 1'b0, 1000, 1, 4, "lw_timeout", len, trapped);
        cmp("lw_timeout_len", 32'(len), 32'(3 + MEM_TIMEOUT));
        cmp("lw_timeout_state", 32'(state), 32'(PH_T));
        cmp("lw_timeout_ready", 32'(instr_ready), 32'(0));
        do_reset();

        // Reset mid-MEM aborts asynchronously, without waiting for a clock edge
        cyc(PH_F, OP_LOAD, 1'b1, 1'b0, 1'b0, 32'h00012083, "abort_fetch");
        cyc(PH_D, OP_LOAD, 1'b0, 1'b0, 1'b0, 32'h0, "abort_dec");
        cyc(PH_E, OP_LOAD, 1'b0, 1'b0, 1'b0, 32'h0, "abort_exe");
        cyc(PH_M, OP_LOAD, 1'b0, 1'b0, 1'b0, 32'h0, "abort_mem");
        #2;
        cmp("abort_pre_memread", 32'(MemRead), 32'(1));
        reset = 1'b1;
        #1;
        cmp("abort_async_state", 32'(state), 32'(PH_F));
        cmp("abort_async_memread", 32'(MemRead), 32'(0));
        cmp("abort_async_ready", 32'(instr_ready), 32'(1));
        @(posedge clk);
        #1;
        do_reset();
        cyc(PH_F, OP_LOAD, 1'b0, 1'b1, 1'b0, 32'h0, "abort_after");

        // Random instruction stream with input noise outside the handshaking states
        for (int n = 0; n < 80; n++) begin
            logic [6:0] ops[6];
            logic [6:0] bad[5];
            logic [6:0] opc;
            int r, wt;
            ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BEQ, OP_JAL};
            bad = '{7'h7F, 7'h00, 7'h37, 7'h67, 7'h73};
            r   = int'($urandom_range(0, 19));
            opc = (r < 18) ? ops[r % 6] : bad[r % 5];
            wt  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 19))
                                              : int'($urandom_range(0, 5));
            run_instr({25'($urandom), opc}, 1'($urandom), wt, int'($urandom_range(0, 2)), 2,
                      "rand", len, trapped);
            cmp("rand_illegal", 32'(illegal), 32'(trapped));
            if (trapped) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
